// File: rtl/resta_c2_serial_if.sv
// resta_c2_serial_if
// Groups the start/done handshake, the operands and the results of the
// bit-serial two's-complement subtractor.
//   inicio   start request, sampled only while ocupado=0
//   a, b     minuend and subtrahend (two's complement), sampled with inicio
//   bi       borrow-in, sampled with inicio
//   ocupado  operation in progress
//   listo    one-cycle pulse when d/boutfin/desborde take a new result
//   d        result a - b - bi, modulo 2^ANCHO
//   boutfin  final unsigned borrow
//   desborde signed overflow
// Modports: master drives the request side, slave is the subtractor.
interface resta_c2_serial_if #(
    parameter int ANCHO = 8
);
    logic             inicio;
    logic [ANCHO-1:0] a;
    logic [ANCHO-1:0] b;
    logic             bi;
    logic             ocupado;
    logic             listo;
    logic [ANCHO-1:0] d;
    logic             boutfin;
    logic             desborde;

    modport master (
        output inicio, a, b, bi,
        input  ocupado, listo, d, boutfin, desborde
    );

    modport slave (
        input  inicio, a, b, bi,
        output ocupado, listo, d, boutfin, desborde
    );
endinterface

// File: rtl/resta_c2_serial.sv
// resta_c2_serial
// Bit-serial two's-complement subtractor: d = a - b - bi, one bit per clock,
// LSB first. Trades latency for area next to the parallel adder.
// Ports:
//   clk    clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    resta_c2_serial_if.slave: inicio/a/b/bi in, ocupado/listo/d/
//          boutfin/desborde out
// Timing: a start accepted at edge k yields listo in the cycle after edge
// k+ANCHO+1; ocupado stays high through that listo cycle, so any inicio up to
// and including the listo cycle is ignored.
module resta_c2_serial #(
    parameter int ANCHO = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    resta_c2_serial_if.slave  bus
);
    localparam int CW = $clog2(ANCHO);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESTA = 2'd1,
        FIN   = 2'd2
    } estado_t;

    estado_t          estado;
    logic [ANCHO-1:0] sa;
    logic [ANCHO-1:0] sb;
    logic [ANCHO-1:0] sr;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             amsb;
    logic             bmsb;
    logic             dbit;
    logic             br_next;

    // One full-subtractor cell working on the current LSBs of the shifting
    // operand registers.
    assign dbit    = sa[0] ^ sb[0] ^ br;
    assign br_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);

    // Sequencer and datapath. The operand MSBs are kept aside at start
    // because the operand registers are shifted away during RESTA, and the
    // overflow test in FIN still needs them. The result register only
    // reaches d in FIN, so partial results never show on the outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado       <= IDLE;
            sa           <= '0;
            sb           <= '0;
            sr           <= '0;
            cnt          <= '0;
            br           <= 1'b0;
            amsb         <= 1'b0;
            bmsb         <= 1'b0;
            bus.ocupado  <= 1'b0;
            bus.listo    <= 1'b0;
            bus.d        <= '0;
            bus.boutfin  <= 1'b0;
            bus.desborde <= 1'b0;
        end else begin
            bus.listo <= 1'b0;
            case (estado)
                IDLE: begin
                    if (bus.inicio && !bus.ocupado) begin
                        sa          <= bus.a;
                        sb          <= bus.b;
                        br          <= bus.bi;
                        amsb        <= bus.a[ANCHO-1];
                        bmsb        <= bus.b[ANCHO-1];
                        cnt         <= '0;
                        bus.ocupado <= 1'b1;
                        estado      <= RESTA;
                    end else begin
                        bus.ocupado <= 1'b0;
                    end
                end
                RESTA: begin
                    sr  <= {dbit, sr[ANCHO-1:1]};
                    sa  <= {1'b0, sa[ANCHO-1:1]};
                    sb  <= {1'b0, sb[ANCHO-1:1]};
                    br  <= br_next;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(ANCHO - 1)) begin
                        estado <= FIN;
                    end
                end
                FIN: begin
                    bus.d        <= sr;
                    bus.boutfin  <= br;
                    bus.desborde <= (amsb != bmsb) && (sr[ANCHO-1] != amsb);
                    bus.listo    <= 1'b1;
                    estado       <= IDLE;
                end
                default: begin
                    estado <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_resta_c2_serial.sv
// tb_resta_c2_serial
// Self-checking bench for resta_c2_serial with ANCHO=8. Inputs are driven and
// outputs sampled on the falling clock edge. A table of hand-computed vectors
// is followed by hand-written sequences for ignored starts, back-to-back
// starts and mid-operation reset, then a random sweep against an arithmetic
// reference.
module tb_resta_c2_serial;
    localparam int ANCHO   = 8;
    localparam int LATENCY = ANCHO + 1;
    localparam int TIMEOUT = 40;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bi;
        logic [7:0] d;
        logic       bout;
        logic       ovf;
    } vec_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    resta_c2_serial_if #(.ANCHO(ANCHO)) bus ();

    resta_c2_serial #(.ANCHO(ANCHO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: every check goes through here.
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Issues one start at the current falling edge, scrambles the operands
    // after the sampling edge, then waits (bounded) for listo. Returns the
    // number of rising edges between the sampling edge and listo.
    task automatic applyStimulus(input logic [7:0] va, input logic [7:0] vb,
                                 input logic vbi, output int lat);
        bus.inicio = 1'b1;
        bus.a      = va;
        bus.b      = vb;
        bus.bi     = vbi;
        @(negedge clk);
        bus.inicio = 1'b0;
        bus.a      = 8'($urandom);
        bus.b      = 8'($urandom);
        bus.bi     = 1'($urandom);
        chk("ocupado_after_start", bus.ocupado, 1'b1);
        lat = 0;
        while (!bus.listo && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Checks the result in the listo cycle, then that listo lasts one cycle
    // and ocupado has dropped. Leaves time at a falling edge with ocupado=0.
    task automatic checkOutput(input string name, input logic [7:0] ed,
                               input logic eb, input logic eo, input int lat);
        chk({name, " latency"}, lat, LATENCY);
        chk({name, " d"}, bus.d, ed);
        chk({name, " boutfin"}, bus.boutfin, eb);
        chk({name, " desborde"}, bus.desborde, eo);
        chk({name, " ocupado_in_listo"}, bus.ocupado, 1'b1);
        @(negedge clk);
        chk({name, " listo_pulse_width"}, bus.listo, 1'b0);
        chk({name, " ocupado_after"}, bus.ocupado, 1'b0);
        chk({name, " d_held"}, bus.d, ed);
    endtask

    initial begin
        vec_t       vecs[10];
        int         lat;
        int         n;
        int         pulses;
        int         first_lat;
        logic [7:0] cap_d;
        logic       cap_b;
        logic       cap_o;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rbi;
        logic [8:0] diff;
        logic [7:0] ed;
        logic       eo;

        total = 0;
        bad   = 0;

        vecs[0] = '{8'h0A, 8'h05, 1'b0, 8'h05, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[2] = '{8'h05, 8'h05, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[5] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[6] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[7] = '{8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b1};
        vecs[8] = '{8'h3C, 8'h5A, 1'b0, 8'hE2, 1'b1, 1'b0};
        vecs[9] = '{8'h7F, 8'h80, 1'b1, 8'hFE, 1'b1, 1'b1};

        bus.inicio = 1'b0;
        bus.a      = 8'h00;
        bus.b      = 8'h00;
        bus.bi     = 1'b0;
        rst_n      = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset ocupado", bus.ocupado, 1'b0);
        chk("reset listo", bus.listo, 1'b0);
        chk("reset d", bus.d, 8'h00);
        chk("reset boutfin", bus.boutfin, 1'b0);
        chk("reset desborde", bus.desborde, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].bi, lat);
            checkOutput($sformatf("vec%0d", i), vecs[i].d, vecs[i].bout, vecs[i].ovf, lat);
        end

        // Reset at cycle 5 of an operation: no listo, outputs back to zero
        // (the previous vector left d=FE and both flags set).
        bus.inicio = 1'b1;
        bus.a      = 8'h33;
        bus.b      = 8'h11;
        bus.bi     = 1'b0;
        @(negedge clk);
        bus.inicio = 1'b0;
        pulses     = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (bus.listo) pulses++;
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort d", bus.d, 8'h00);
        chk("abort ocupado", bus.ocupado, 1'b0);
        chk("abort boutfin", bus.boutfin, 1'b0);
        chk("abort desborde", bus.desborde, 1'b0);
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (bus.listo) pulses++;
        end
        chk("abort listo_count", pulses, 0);
        applyStimulus(8'h20, 8'h01, 1'b0, lat);
        checkOutput("after_abort", 8'h1F, 1'b0, 1'b0, lat);

        // Starts while busy (mid-operation and in the listo cycle) must be
        // ignored; one listo only, result of the first operands.
        bus.inicio = 1'b1;
        bus.a      = 8'h10;
        bus.b      = 8'h03;
        bus.bi     = 1'b0;
        @(negedge clk);
        bus.inicio = 1'b0;
        n          = 0;
        pulses     = 0;
        first_lat  = -1;
        cap_d      = 8'h00;
        cap_b      = 1'b0;
        cap_o      = 1'b0;
        while (n < 25) begin
            @(negedge clk);
            n++;
            if (bus.listo) begin
                pulses++;
                if (pulses == 1) begin
                    first_lat = n;
                    cap_d     = bus.d;
                    cap_b     = bus.boutfin;
                    cap_o     = bus.desborde;
                end
                bus.inicio = 1'b1;
                bus.a      = 8'hFF;
                bus.b      = 8'hFF;
            end else if (n == 4) begin
                bus.inicio = 1'b1;
                bus.a      = 8'hFF;
                bus.b      = 8'hFF;
            end else begin
                bus.inicio = 1'b0;
            end
        end
        bus.inicio = 1'b0;
        chk("busy listo_count", pulses, 1);
        chk("busy latency", first_lat, LATENCY);
        chk("busy d", cap_d, 8'h0D);
        chk("busy boutfin", cap_b, 1'b0);
        chk("busy desborde", cap_o, 1'b0);
        chk("busy ocupado_after", bus.ocupado, 1'b0);

        // Back-to-back: start issued in the first cycle with ocupado=0.
        applyStimulus(8'hFF, 8'hFF, 1'b0, lat);
        checkOutput("b2b_first", 8'h00, 1'b0, 1'b0, lat);
        applyStimulus(8'h0A, 8'h05, 1'b0, lat);
        checkOutput("b2b_second", 8'h05, 1'b0, 1'b0, lat);

        // Random sweep with random idle gaps (0 = back-to-back).
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rbi  = 1'($urandom);
            diff = {1'b0, ra} - {1'b0, rb} - {8'h00, rbi};
            ed   = diff[7:0];
            eo   = (ra[7] != rb[7]) && (ed[7] != ra[7]);
            applyStimulus(ra, rb, rbi, lat);
            checkOutput($sformatf("rnd%0d a=%0h b=%0h bi=%0b", i, ra, rb, rbi),
                        ed, diff[8], eo, lat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
